// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one small result FIFO per producer and a
// round-robin pick of up to CDB_PORTS FIFO heads per cycle, broadcast
// from registered outputs.
module cdb_arbiter #(
  parameter int NUM_SRC    = 5,
  parameter int CDB_PORTS  = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 3,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [CDB_PORTS-1:0]        cdb_valid,
  output logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
  output logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  output logic [CDB_PORTS*SRC_W-1:0]  cdb_src,
  output logic                        dup_tag_err
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  // Storage slot addressed by a circular pointer (extra MSB is the wrap bit).
  function automatic logic [AW-1:0] slot(input logic [PTR_W-1:0] p);
    if (FIFO_DEPTH == 1) return '0;
    return AW'(p);
  endfunction

  logic [TAG_W-1:0]  tag_mem  [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr     [NUM_SRC];
  logic [PTR_W-1:0]  rptr     [NUM_SRC];
  logic [PTR_W-1:0]  count    [NUM_SRC];
  logic [TAG_W-1:0]  head_tag [NUM_SRC];
  logic [DATA_W-1:0] head_data[NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     rr_next;
  logic [SRC_W-1:0]     last_sel;
  logic [SRC_W-1:0]     s;
  logic                 found;
  logic [SRC_W-1:0]     sel [CDB_PORTS];
  logic [CDB_PORTS-1:0] port_vld;
  logic                 dup_now;

  // FIFO occupancy and head entries
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      count[i]     = wptr[i] - rptr[i];
      empty[i]     = (count[i] == '0);
      head_tag[i]  = tag_mem[i][slot(rptr[i])];
      head_data[i] = data_mem[i][slot(rptr[i])];
    end
  end

  // Round-robin pick: port p takes the p-th non-empty source found scanning from rr_ptr
  always_comb begin
    grant    = '0;
    port_vld = '0;
    last_sel = rr_ptr;
    s        = '0;
    found    = 1'b0;
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      sel[p] = '0;
      found  = 1'b0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        s = SRC_W'((32'(rr_ptr) + k) % NUM_SRC);
        if (!found && !empty[s] && !grant[s]) begin
          found    = 1'b1;
          grant[s] = 1'b1;
          sel[p]   = s;
          last_sel = s;
        end
      end
      port_vld[p] = found;
    end
    rr_next = (last_sel == SRC_W'(NUM_SRC - 1)) ? '0 : last_sel + SRC_W'(1);
  end

  // Accept handshake; a granted full FIFO frees its head slot this cycle
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !rst && !flush && ((count[i] < PTR_W'(FIFO_DEPTH)) || grant[i]);
      push[i]      = src_valid[i] && src_ready[i];
    end
  end

  // Detect equal tags among the ports about to be broadcast
  always_comb begin
    dup_now = 1'b0;
    for (int unsigned p = 0; p < CDB_PORTS; p++) begin
      for (int unsigned q = p + 1; q < CDB_PORTS; q++) begin
        if (port_vld[p] && port_vld[q] && (head_tag[sel[p]] == head_tag[sel[q]]))
          dup_now = 1'b1;
      end
    end
  end

  // FIFO pointers and round-robin pointer; flush overrides push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i])  wptr[i] <= wptr[i] + PTR_W'(1);
        if (grant[i]) rptr[i] <= rptr[i] + PTR_W'(1);
      end
      if (|grant) rr_ptr <= rr_next;
    end
  end

  // FIFO storage writes (no reset needed; occupancy is tracked by the pointers)
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        tag_mem[i][slot(wptr[i])]  <= src_tag[i*TAG_W +: TAG_W];
        data_mem[i][slot(wptr[i])] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered broadcast; idle ports keep their last tag/data/src
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid   <= '0;
      cdb_tag     <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
      dup_tag_err <= 1'b0;
    end else if (flush) begin
      cdb_valid <= '0;
    end else begin
      cdb_valid <= port_vld;
      for (int unsigned p = 0; p < CDB_PORTS; p++) begin
        if (port_vld[p]) begin
          cdb_tag[p*TAG_W +: TAG_W]    <= head_tag[sel[p]];
          cdb_data[p*DATA_W +: DATA_W] <= head_data[sel[p]];
          cdb_src[p*SRC_W +: SRC_W]    <= sel[p];
        end
      end
      if (dup_now) dup_tag_err <= 1'b1;
    end
  end

endmodule
